// File: rtl/bnn_uart_tx.sv
// UART transmitter for the BNN controller: byte FIFO feeding an 8N1/8N2 serialiser
// that advances one bit per baud_clk enable and honours peer_ready at frame boundaries.
module bnn_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_clk,
    input  logic [7:0] data_in,
    input  logic       tx_start,
    output logic       tx_ready,
    input  logic       peer_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_buffer_empty,
    output logic       overflow
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             full_c;
    logic             push_c;
    logic             pop_c;
    logic             start_ok_c;
    logic             stop_last_c;

    state_e           state_q;
    state_e           state_d;
    logic             tx_q;
    logic             tx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [BIT_W-1:0] bit_idx_q;
    logic [BIT_W-1:0] bit_idx_d;
    logic             stop_cnt_q;
    logic             stop_cnt_d;

    // tx_ready is sampled before any pop, so a push into a full FIFO is dropped
    // even in the cycle the FSM pops it.
    assign full_c      = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_c      = tx_start && !full_c;
    assign start_ok_c  = (count_q != '0) && peer_ready;
    assign stop_last_c = (stop_cnt_q == 1'(STOP_BITS - 1));

    assign tx_ready        = !full_c;
    assign tx_buffer_empty = (count_q == '0);
    assign tx_busy         = (state_q != IDLE);
    assign tx              = tx_q;
    assign overflow        = overflow_q;

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (tx_start && full_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Serialiser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    // Next-state logic; everything holds between baud ticks
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        pop_c      = 1'b0;

        if (baud_clk) begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (start_ok_c) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        shift_d = mem[rd_ptr_q];
                        pop_c   = 1'b1;
                    end
                end
                START: begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = '0;
                end
                DATA: begin
                    if (bit_idx_q == BIT_W'(7)) begin
                        state_d    = STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
                STOP: begin
                    if (!stop_last_c) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end else if (start_ok_c) begin
                        // back-to-back frame: no idle bit between stop and start
                        state_d = START;
                        tx_d    = 1'b0;
                        shift_d = mem[rd_ptr_q];
                        pop_c   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

endmodule
